psram_bist: RTL and testbench

- Parametrised PSRAM built-in self-test sequencer; next generation of the single-byte write/read-back check in the top level.
- Sits between the top-level state machine and memCtrl, driving memCtrl's request interface directly.
- Writes a selectable pattern over an address window, waits a settle period, reads the window back, compares it, and repeats for N passes.
- Reports pass/fail, error count, first failing address/data and controller timeouts.

---
 rtl/gm64_pkg.sv | 26 ++
 rtl/bist_pattern_gen.sv | 47 ++++
 rtl/psram_bist.sv | 190 +++++++++++++++++++
 tb/tb_psram_bist.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm64_pkg.sv
// Shared types for the PSRAM self-test: sequencer states, pattern modes and
// the memCtrl idle state encoding that the top level decodes into i_ramIdle.
package gm64_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StSettle,
    StRdReq,
    StRdWait,
    StCheck,
    StDone
  } bist_state_e;

  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_ADDR  = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_e;

  localparam int unsigned MemStateW = 3;
  localparam logic [MemStateW-1:0] MemStateIdle = 3'd0;

endpackage

// File: rtl/bist_pattern_gen.sv
// Test pattern source; one LFSR is shared by the write and read phases so the
// read phase regenerates exactly the sequence that was written.
module bist_pattern_gen
  import gm64_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       SH_W      = 3,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pat_mode_e         mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [SH_W-1:0]   index,
  input  logic [DATA_W-1:0] address,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] lfsr_q, lfsr_d, lfsr_cur;

  // load bypasses the register so the first word of a phase already sees the seed
  always_comb begin
    lfsr_cur = lfsr_q;
    if (load) lfsr_cur = (seed == '0) ? DATA_W'(1) : seed;
    lfsr_d = lfsr_cur;
    if (advance) lfsr_d = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= DATA_W'(1);
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    pattern = seed;
    unique case (mode)
      PAT_CONST: pattern = seed;
      PAT_ADDR:  pattern = address ^ seed;
      PAT_WALK:  pattern = (seed << index) | (seed >> (DATA_W - 32'(index)));
      PAT_LFSR:  pattern = lfsr_cur;
      default:   pattern = seed;
    endcase
  end

endmodule

// File: rtl/psram_bist.sv
// PSRAM self-test sequencer: write a pattern window, settle, read back and
// compare for a number of passes, driving memCtrl's request interface.
module psram_bist
  import gm64_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 24,
  parameter int unsigned       DATA_W         = 8,
  parameter logic [ADDR_W-1:0] START_ADDR     = ADDR_W'(24'h001000),
  parameter int unsigned       LENGTH         = 256,
  parameter int unsigned       SETTLE_CYCLES  = 50000,
  parameter int unsigned       NUM_PASSES     = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] LFSR_TAPS      = DATA_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_bank,
  output logic              o_cs,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_bank,
  output logic [DATA_W-1:0] o_dataToWrite,
  input  logic [DATA_W-1:0] i_dataRead,
  input  logic              i_busy,
  input  logic              i_dataReady,
  input  logic              i_ramIdle,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [15:0]       o_errCount,
  output logic [ADDR_W-1:0] o_firstErrAddr,
  output logic [DATA_W-1:0] o_firstErrData
);

  localparam int unsigned       ShW     = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LENGTH - 1);

  bist_state_e       state_q, state_d;
  pat_mode_e         mode_q;
  logic [ADDR_W-1:0] index_q, index_d, addr_q, ferr_addr_q;
  logic [DATA_W-1:0] seed_q, wdata_q, rdata_q, ferr_data_q, pattern;
  logic [31:0]       cnt_q, pass_q;
  logic [15:0]       err_q;
  logic bank_q, cs_q, write_q, busy_seen_q, timeout_q;
  logic start, req_ok, issue, last_idx, more_pass, wr_done, rd_ok;
  logic settle_done, waiting, tmo_hit, abort, pass_roll, load, advance, mismatch;

  assign start       = i_start && (state_q == StIdle || state_q == StDone);
  assign req_ok      = i_ramIdle && !i_busy;
  assign issue       = req_ok && (state_q == StWrReq || state_q == StRdReq);
  assign last_idx    = (index_q == LastIdx);
  assign more_pass   = (pass_q < NUM_PASSES - 1);
  assign wr_done     = (state_q == StWrWait) && busy_seen_q && !i_busy;
  assign rd_ok       = i_dataReady && !i_busy;
  assign settle_done = (cnt_q + 32'd1 >= SETTLE_CYCLES);
  assign waiting     = (state_q == StWrReq) || (state_q == StWrWait) ||
                       (state_q == StRdReq) || (state_q == StRdWait);
  assign tmo_hit     = waiting && (cnt_q + 32'd1 >= TIMEOUT_CYCLES);
  assign pass_roll   = (state_q == StCheck) && last_idx && more_pass;
  assign load        = (state_q == StWrReq || state_q == StRdReq) && (index_q == '0);
  assign advance     = wr_done || (state_q == StCheck);
  assign mismatch    = (rdata_q != pattern);

  bist_pattern_gen #(
    .DATA_W    (DATA_W),
    .SH_W      (ShW),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_pattern_gen (
    .clk     (clk),
    .rst_n   (reset),
    .mode    (mode_q),
    .seed    (seed_q),
    .index   (index_q[ShW-1:0]),
    .address (addr_q[DATA_W-1:0]),
    .load    (load),
    .advance (advance),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StWrReq;
      StWrReq:  if (req_ok) state_d = StWrWait;
                else if (tmo_hit) abort = 1'b1;
      StWrWait: if (wr_done) state_d = last_idx ? StSettle : StWrReq;
                else if (tmo_hit) abort = 1'b1;
      StSettle: if (settle_done) state_d = StRdReq;
      StRdReq:  if (req_ok) state_d = StRdWait;
                else if (tmo_hit) abort = 1'b1;
      StRdWait: if (rd_ok) state_d = StCheck;
                else if (tmo_hit) abort = 1'b1;
      StCheck:  if (!last_idx) state_d = StRdReq;
                else if (more_pass) state_d = StWrReq;
                else state_d = StDone;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StDone;
  end

  always_comb begin
    index_d = index_q;
    if (start) index_d = '0;
    else if (wr_done || state_q == StCheck) index_d = last_idx ? '0 : index_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= PAT_CONST;
      index_q     <= '0;
      addr_q      <= START_ADDR;
      seed_q      <= '0;
      bank_q      <= 1'b0;
      pass_q      <= '0;
      cnt_q       <= '0;
      cs_q        <= 1'b1;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      busy_seen_q <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      addr_q  <= START_ADDR + index_d;
      cs_q    <= 1'b1;
      if (state_d != state_q) cnt_q <= '0;
      else if (waiting || state_q == StSettle) cnt_q <= cnt_q + 32'd1;
      if (start) begin
        mode_q      <= pat_mode_e'(i_mode);
        seed_q      <= i_seed;
        bank_q      <= i_bank;
        pass_q      <= '0;
        err_q       <= '0;
        ferr_addr_q <= '0;
        ferr_data_q <= '0;
        timeout_q   <= 1'b0;
      end
      if (pass_roll) begin
        pass_q <= pass_q + 32'd1;
        seed_q <= ~seed_q;
      end
      if (issue) begin
        cs_q        <= 1'b0;
        write_q     <= (state_q == StWrReq);
        busy_seen_q <= 1'b0;
        if (state_q == StWrReq) wdata_q <= pattern;
      end
      if (state_q == StWrWait && i_busy) busy_seen_q <= 1'b1;
      if (state_q == StRdWait && rd_ok) rdata_q <= i_dataRead;
      if (state_q == StCheck && mismatch) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == '0) begin
          ferr_addr_q <= addr_q;
          ferr_data_q <= rdata_q;
        end
      end
      if (abort) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    o_running = !(state_q == StIdle || state_q == StDone);
    o_done    = (state_q == StDone);
    o_pass    = o_done && (err_q == '0) && !timeout_q;
  end

  assign o_cs           = cs_q;
  assign o_write        = write_q;
  assign o_address      = addr_q;
  assign o_bank         = bank_q;
  assign o_dataToWrite  = wdata_q;
  assign o_timeout      = timeout_q;
  assign o_errCount     = err_q;
  assign o_firstErrAddr = ferr_addr_q;
  assign o_firstErrData = ferr_data_q;

endmodule

// File: tb/tb_psram_bist.sv
// Directed bench for psram_bist: behavioural memCtrl model plus a request
// scoreboard filled from an independent pattern model.
module tb_psram_bist;
  import gm64_pkg::*;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LENGTH     = 4;
  localparam int unsigned NUM_PASSES = 2;
  localparam logic [23:0] START      = 24'hFFFFFE;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
    logic        bank;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [7:0]  i_seed = 8'h00;
  logic        i_bank = 1'b0;
  logic        o_cs, o_write, o_bank, o_running, o_done, o_pass, o_timeout;
  logic [23:0] o_address, o_firstErrAddr;
  logic [7:0]  o_dataToWrite, o_firstErrData;
  logic [15:0] o_errCount;
  logic [7:0]  data_read = 8'h00;
  logic        busy = 1'b0;
  logic        data_ready = 1'b0;
  logic [MemStateW-1:0] mem_state = MemStateIdle;
  logic        ram_idle;

  int checks = 0;
  int failures = 0;
  int req_count = 0;
  int busy_cnt = 0;
  bit never_busy = 0;
  bit force_en = 0;
  logic [23:0] force_addr = 24'h0;
  logic [7:0]  force_val = 8'h0;
  int          exp_err;
  logic [23:0] exp_faddr;
  logic [7:0]  exp_fdata;
  req_t        sb_q[$];
  req_t        pend, ex;
  logic [7:0]  mem [logic [23:0]];

  assign ram_idle = (mem_state == MemStateIdle);

  always #5 clk = ~clk;

  psram_bist #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .START_ADDR     (START),
    .LENGTH         (LENGTH),
    .SETTLE_CYCLES  (20),
    .NUM_PASSES     (NUM_PASSES),
    .TIMEOUT_CYCLES (1024),
    .LFSR_TAPS      (8'hB8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_mode         (i_mode),
    .i_seed         (i_seed),
    .i_bank         (i_bank),
    .o_cs           (o_cs),
    .o_write        (o_write),
    .o_address      (o_address),
    .o_bank         (o_bank),
    .o_dataToWrite  (o_dataToWrite),
    .i_dataRead     (data_read),
    .i_busy         (busy),
    .i_dataReady    (data_ready),
    .i_ramIdle      (ram_idle),
    .o_running      (o_running),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_timeout      (o_timeout),
    .o_errCount     (o_errCount),
    .o_firstErrAddr (o_firstErrAddr),
    .o_firstErrData (o_firstErrData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
    checks++;
    assert (obs === exv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exv);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] p, input int idx,
                                     input logic [23:0] a, input logic [7:0] l);
    logic [7:0] r;
    r = p;
    case (m)
      2'd0: r = p;
      2'd1: r = a[7:0] ^ p;
      2'd2: for (int k = 0; k < idx % 8; k++) r = {r[6:0], r[7]};
      default: r = l;
    endcase
    return r;
  endfunction

  // Memory model: busy for 3 cycles per request, read data valid as busy drops.
  always @(negedge clk) begin
    data_ready = 1'b0;
    if (!reset) begin
      busy_cnt  = 0;
      busy      = 1'b0;
      mem_state = MemStateIdle;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        busy      = 1'b0;
        mem_state = MemStateIdle;
        if (pend.wr) mem[pend.addr] = pend.data;
        else begin
          data_read = mem.exists(pend.addr) ? mem[pend.addr] : 8'h00;
          if (force_en && pend.addr == force_addr) data_read = force_val;
          data_ready = 1'b1;
        end
      end
    end else if (o_cs == 1'b0) begin
      req_count++;
      pend = '{o_write, o_address, o_dataToWrite, o_bank};
      chk("sb_expected_req", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        ex = sb_q.pop_front();
        chk("req_write", 32'(o_write), 32'(ex.wr));
        chk("req_addr", 32'(o_address), 32'(ex.addr));
        chk("req_bank", 32'(o_bank), 32'(ex.bank));
        if (ex.wr) chk("req_wdata", 32'(o_dataToWrite), 32'(ex.data));
      end
      if (!never_busy) begin
        busy      = 1'b1;
        busy_cnt  = 3;
        mem_state = ~MemStateIdle;
      end
    end
  end

  task automatic push_run(input logic [1:0] m, input logic [7:0] s, input logic b);
    logic [7:0] p, l, d, rd;
    logic [23:0] a;
    exp_err = 0; exp_faddr = '0; exp_fdata = '0;
    for (int ps = 0; ps < NUM_PASSES; ps++) begin
      p = (ps % 2 == 1) ? ~s : s;
      l = (p == 8'h00) ? 8'h01 : p;
      for (int i = 0; i < LENGTH; i++) begin
        a = START + 24'(i);
        d = pat(m, p, i, a, l);
        sb_q.push_back('{1'b1, a, d, b});
        l = lfsr_step(l);
      end
      l = (p == 8'h00) ? 8'h01 : p;
      for (int i = 0; i < LENGTH; i++) begin
        a = START + 24'(i);
        d = pat(m, p, i, a, l);
        sb_q.push_back('{1'b0, a, d, b});
        rd = (force_en && a == force_addr) ? force_val : d;
        if (rd != d) begin
          if (exp_err == 0) begin
            exp_faddr = a;
            exp_fdata = rd;
          end
          exp_err++;
        end
        l = lfsr_step(l);
      end
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] s, input logic b);
    i_mode = m; i_seed = s; i_bank = b; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_cs"}, 32'(o_cs), 32'd1);
    chk({nm, "_write"}, 32'(o_write), 32'd0);
    chk({nm, "_addr"}, 32'(o_address), 32'(START));
    chk({nm, "_bank"}, 32'(o_bank), 32'd0);
    chk({nm, "_wdata"}, 32'(o_dataToWrite), 32'd0);
    chk({nm, "_running"}, 32'(o_running), 32'd0);
    chk({nm, "_done"}, 32'(o_done), 32'd0);
    chk({nm, "_pass"}, 32'(o_pass), 32'd0);
    chk({nm, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({nm, "_errcnt"}, 32'(o_errCount), 32'd0);
    chk({nm, "_ferr_addr"}, 32'(o_firstErrAddr), 32'd0);
    chk({nm, "_ferr_data"}, 32'(o_firstErrData), 32'd0);
  endtask

  task automatic run(input string nm, input logic [1:0] m, input logic [7:0] s, input logic b,
                     input bit poke);
    bit got;
    sb_q.delete();
    req_count = 0;
    push_run(m, s, b);
    pulse_start(m, s, b);
    chk({nm, "_running"}, 32'(o_running), 32'd1);
    if (poke) begin
      repeat (10) @(negedge clk);
      pulse_start(~m, ~s, ~b);
    end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = o_done;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_running_end"}, 32'(o_running), 32'd0);
    chk({nm, "_pass"}, 32'(o_pass), 32'(exp_err == 0));
    chk({nm, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({nm, "_errcnt"}, 32'(o_errCount), 32'(exp_err));
    chk({nm, "_ferr_addr"}, 32'(o_firstErrAddr), 32'(exp_faddr));
    chk({nm, "_ferr_data"}, 32'(o_firstErrData), 32'(exp_fdata));
    chk({nm, "_req_count"}, 32'(req_count), 32'(2 * LENGTH * NUM_PASSES));
    chk({nm, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    run("const0", 2'd0, 8'h00, 1'b1, 0);
    force_en = 1; force_addr = 24'h000000; force_val = 8'h5A;
    run("addr_err", 2'd1, 8'hFF, 1'b0, 0);
    force_en = 0;
    run("lfsr0", 2'd3, 8'h00, 1'b1, 0);
    run("walk_poke", 2'd2, 8'h01, 1'b0, 1);

    // Reset while the first read is outstanding.
    sb_q.delete();
    push_run(2'd0, 8'h3C, 1'b0);
    pulse_start(2'd0, 8'h3C, 1'b0);
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = (o_cs === 1'b0 && o_write === 1'b0);
    end
    chk("rdwait_reached", 32'(got), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset("midrst");
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("after_rst", 2'd1, 8'h11, 1'b0, 0);

    // Controller never goes busy.
    never_busy = 1;
    sb_q.delete();
    req_count = 0;
    sb_q.push_back('{1'b1, START, 8'h77, 1'b0});
    pulse_start(2'd0, 8'h77, 1'b0);
    repeat (1000) @(negedge clk);
    chk("tmo_not_early", 32'(o_done), 32'd0);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = o_done;
    end
    chk("tmo_done", 32'(got), 32'd1);
    chk("tmo_flag", 32'(o_timeout), 32'd1);
    chk("tmo_cs", 32'(o_cs), 32'd1);
    chk("tmo_pass", 32'(o_pass), 32'd0);
    chk("tmo_running", 32'(o_running), 32'd0);
    chk("tmo_req_count", 32'(req_count), 32'd1);
    never_busy = 0;

    run("restart", 2'd3, 8'h5A, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
